// File: rtl/icache_miss_ctrl.sv
// rtl/icache_miss_ctrl.sv - instruction cache miss controller: valid/victim state, refill FSM, flush
module icache_miss_ctrl #(
  parameter int TAG_WIDTH = 7,
  parameter int NUM_WAY   = 2,
  parameter int WAY_DEPTH = 1,
  parameter int SET_DEPTH = 5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           lookup_valid_i,
  input  logic [SET_DEPTH-1:0]           lookup_set_i,
  input  logic [TAG_WIDTH-1:0]           lookup_tag_i,
  input  logic                           cache_hit_i,
  output logic [NUM_WAY-1:0]             way_valid_o,
  output logic                           stall_o,
  output logic                           mem_req_valid_o,
  input  logic                           mem_req_ready_i,
  output logic [TAG_WIDTH+SET_DEPTH-1:0] mem_req_addr_o,
  input  logic                           mem_rsp_valid_i,
  output logic                           tag_wr_en_o,
  output logic [SET_DEPTH-1:0]           tag_wr_set_o,
  output logic [WAY_DEPTH-1:0]           tag_wr_way_o,
  output logic [TAG_WIDTH-1:0]           tag_wr_tag_o,
  input  logic                           invalidate_i
);

  localparam int NUM_SET = 2 ** SET_DEPTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_FILL
  } state_t;

  state_t state_q, state_d;

  logic [NUM_WAY-1:0]   valid_q [NUM_SET];
  logic [WAY_DEPTH-1:0] ptr_q   [NUM_SET];
  logic [SET_DEPTH-1:0] set_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic [WAY_DEPTH-1:0] victim_q;
  logic                 flush_pend_q;

  logic [NUM_WAY-1:0]   lookup_bits;
  logic [WAY_DEPTH-1:0] victim_d;
  logic [WAY_DEPTH-1:0] victim_next;
  logic                 miss_start;

  assign lookup_bits     = valid_q[lookup_set_i];
  assign way_valid_o     = lookup_bits;
  assign miss_start      = (state_q == S_IDLE) && lookup_valid_i && !cache_hit_i && !invalidate_i;
  assign mem_req_addr_o  = {tag_q, set_q};
  assign tag_wr_set_o    = set_q;
  assign tag_wr_way_o    = victim_q;
  assign tag_wr_tag_o    = tag_q;
  assign victim_next     = (victim_q == WAY_DEPTH'(NUM_WAY - 1)) ? '0 : victim_q + WAY_DEPTH'(1);

  // Victim: lowest-index invalid way of the looked-up set, else its round-robin pointer
  always_comb begin
    victim_d = ptr_q[lookup_set_i];
    for (int w = NUM_WAY - 1; w >= 0; w--) begin
      if (!lookup_bits[w]) victim_d = WAY_DEPTH'(w);
    end
  end

  // Next-state and per-state outputs
  always_comb begin
    state_d         = state_q;
    stall_o         = 1'b0;
    mem_req_valid_o = 1'b0;
    tag_wr_en_o     = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall_o = lookup_valid_i && (!cache_hit_i || invalidate_i);
        if (miss_start) state_d = S_REQ;
      end
      S_REQ: begin
        stall_o         = 1'b1;
        mem_req_valid_o = 1'b1;
        if (mem_req_ready_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        stall_o = 1'b1;
        if (mem_rsp_valid_i) state_d = S_FILL;
      end
      S_FILL: begin
        stall_o     = 1'b1;
        tag_wr_en_o = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset aborts any refill in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Capture the missing line and its chosen victim when a miss is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      set_q    <= '0;
      tag_q    <= '0;
      victim_q <= '0;
    end else if (miss_start) begin
      set_q    <= lookup_set_i;
      tag_q    <= lookup_tag_i;
      victim_q <= victim_d;
    end
  end

  // Valid bits, victim pointers and deferred flush; a flush during a refill lands after the fill
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NUM_SET; s++) begin
        valid_q[s] <= '0;
        ptr_q[s]   <= '0;
      end
      flush_pend_q <= 1'b0;
    end else begin
      if ((state_q != S_IDLE) && invalidate_i) flush_pend_q <= 1'b1;
      if (state_q == S_FILL) begin
        valid_q[set_q][victim_q] <= 1'b1;
        if (victim_q == ptr_q[set_q]) ptr_q[set_q] <= victim_next;
        if (flush_pend_q || invalidate_i) begin
          for (int s = 0; s < NUM_SET; s++) valid_q[s] <= '0;
        end
        flush_pend_q <= 1'b0;
      end else if ((state_q == S_IDLE) && invalidate_i) begin
        for (int s = 0; s < NUM_SET; s++) valid_q[s] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_icache_miss_ctrl.sv
// tb/tb_icache_miss_ctrl.sv - scoreboard bench for icache_miss_ctrl
module tb_icache_miss_ctrl;

  localparam int TW = 7;
  localparam int NW = 2;
  localparam int WD = 1;
  localparam int SD = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          lookup_valid_i;
  logic [SD-1:0] lookup_set_i;
  logic [TW-1:0] lookup_tag_i;
  logic          cache_hit_i;
  logic [NW-1:0] way_valid_o;
  logic          stall_o;
  logic          mem_req_valid_o;
  logic          mem_req_ready_i;
  logic [TW+SD-1:0] mem_req_addr_o;
  logic          mem_rsp_valid_i;
  logic          tag_wr_en_o;
  logic [SD-1:0] tag_wr_set_o;
  logic [WD-1:0] tag_wr_way_o;
  logic [TW-1:0] tag_wr_tag_o;
  logic          invalidate_i;

  int vectors     = 0;
  int miscompares = 0;

  logic [TW+SD-1:0]    exp_req [$];
  logic [SD+WD+TW-1:0] exp_wr  [$];

  icache_miss_ctrl #(
    .TAG_WIDTH(TW), .NUM_WAY(NW), .WAY_DEPTH(WD), .SET_DEPTH(SD)
  ) dut (
    .clk(clk), .rst(rst),
    .lookup_valid_i(lookup_valid_i), .lookup_set_i(lookup_set_i),
    .lookup_tag_i(lookup_tag_i), .cache_hit_i(cache_hit_i),
    .way_valid_o(way_valid_o), .stall_o(stall_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o(mem_req_addr_o), .mem_rsp_valid_i(mem_rsp_valid_i),
    .tag_wr_en_o(tag_wr_en_o), .tag_wr_set_o(tag_wr_set_o),
    .tag_wr_way_o(tag_wr_way_o), .tag_wr_tag_o(tag_wr_tag_o),
    .invalidate_i(invalidate_i)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Scoreboard: pop expected request address / tag write when the DUT produces them
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req_valid_o && mem_req_ready_i) begin
        if (exp_req.size() == 0) check_eq("req_unexpected", 32'(mem_req_addr_o), 32'hFFFF_FFFF);
        else check_eq("req_addr", 32'(mem_req_addr_o), 32'(exp_req.pop_front()));
      end
      if (tag_wr_en_o) begin
        if (exp_wr.size() == 0) check_eq("wr_unexpected", 32'({tag_wr_set_o, tag_wr_way_o, tag_wr_tag_o}), 32'hFFFF_FFFF);
        else check_eq("tag_wr", 32'({tag_wr_set_o, tag_wr_way_o, tag_wr_tag_o}), 32'(exp_wr.pop_front()));
      end
    end
  end

  task automatic check_ways(input logic [SD-1:0] s, input logic [NW-1:0] want);
    lookup_set_i = s;
    #1;
    check_eq($sformatf("way_valid_set%0d", s), 32'(way_valid_o), 32'(want));
  endtask

  // Full miss/refill: rdly cycles of ready low, sdly cycles before response, optional invalidate in WAIT
  task automatic refill(input logic [SD-1:0] s, input logic [TW-1:0] t, input logic [WD-1:0] w,
                        input int rdly, input int sdly, input bit inval_wait);
    @(posedge clk); #1;
    lookup_valid_i = 1'b1; lookup_set_i = s; lookup_tag_i = t; cache_hit_i = 1'b0;
    exp_req.push_back({t, s});
    exp_wr.push_back({s, w, t});
    @(negedge clk);
    check_eq("miss_stall", 32'(stall_o), 32'd1);
    check_eq("miss_no_req_yet", 32'(mem_req_valid_o), 32'd0);
    @(posedge clk); #1;
    lookup_tag_i = ~t;
    for (int i = 0; i < rdly; i++) begin
      @(negedge clk);
      check_eq("req_hold_valid", 32'(mem_req_valid_o), 32'd1);
      check_eq("req_hold_addr", 32'(mem_req_addr_o), 32'({t, s}));
      check_eq("req_hold_stall", 32'(stall_o), 32'd1);
      @(posedge clk); #1;
    end
    lookup_valid_i = 1'b0;
    mem_req_ready_i = 1'b1;
    @(negedge clk);
    check_eq("req_valid", 32'(mem_req_valid_o), 32'd1);
    @(posedge clk); #1;
    mem_req_ready_i = 1'b0;
    if (inval_wait) begin
      invalidate_i = 1'b1;
      @(posedge clk); #1;
      invalidate_i = 1'b0;
    end
    for (int i = 0; i < sdly; i++) begin
      @(negedge clk);
      check_eq("wait_stall", 32'(stall_o), 32'd1);
      check_eq("wait_no_wr", 32'(tag_wr_en_o), 32'd0);
      @(posedge clk); #1;
    end
    mem_rsp_valid_i = 1'b1;
    @(posedge clk); #1;
    mem_rsp_valid_i = 1'b0;
    @(negedge clk);
    check_eq("fill_wr_en", 32'(tag_wr_en_o), 32'd1);
    check_eq("fill_stall", 32'(stall_o), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("post_fill_wr_en", 32'(tag_wr_en_o), 32'd0);
    check_eq("post_fill_stall", 32'(stall_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    lookup_valid_i = 1'b0; lookup_set_i = '0; lookup_tag_i = '0; cache_hit_i = 1'b0;
    mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0; invalidate_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_stall", 32'(stall_o), 32'd0);
    check_eq("rst_req_valid", 32'(mem_req_valid_o), 32'd0);
    check_eq("rst_req_addr", 32'(mem_req_addr_o), 32'd0);
    check_eq("rst_wr_en", 32'(tag_wr_en_o), 32'd0);
    check_eq("rst_wr_fields", 32'({tag_wr_set_o, tag_wr_way_o, tag_wr_tag_o}), 32'd0);
    check_ways(5'd0, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0;

    // Cold miss, then fill/rr replacement sequence in set 3 (zero-wait memory)
    refill(5'd3, 7'h15, 1'b0, 0, 0, 1'b0);
    check_ways(5'd3, 2'b01);
    refill(5'd3, 7'h2A, 1'b1, 0, 0, 1'b0);
    check_ways(5'd3, 2'b11);
    refill(5'd3, 7'h01, 1'b0, 0, 0, 1'b0);
    refill(5'd3, 7'h55, 1'b1, 0, 0, 1'b0);
    check_ways(5'd3, 2'b11);

    // Hit leaves controller idle
    @(posedge clk); #1;
    lookup_valid_i = 1'b1; lookup_set_i = 5'd3; lookup_tag_i = 7'h55; cache_hit_i = 1'b1;
    @(negedge clk);
    check_eq("hit_stall", 32'(stall_o), 32'd0);
    @(posedge clk); #1;
    lookup_valid_i = 1'b0; cache_hit_i = 1'b0;
    @(negedge clk);
    check_eq("hit_no_req", 32'(mem_req_valid_o), 32'd0);

    // Stray response in IDLE ignored
    @(posedge clk); #1;
    mem_rsp_valid_i = 1'b1;
    @(posedge clk); #1;
    mem_rsp_valid_i = 1'b0;
    @(negedge clk);
    check_eq("stray_rsp_wr", 32'(tag_wr_en_o), 32'd0);
    check_eq("stray_rsp_req", 32'(mem_req_valid_o), 32'd0);

    // Backpressured request and delayed response
    refill(5'd7, 7'h33, 1'b0, 5, 2, 1'b0);
    check_ways(5'd7, 2'b01);

    // Invalidate during WAIT: fill completes, then everything is invalid
    refill(5'd9, 7'h44, 1'b0, 0, 1, 1'b1);
    check_ways(5'd9, 2'b00);
    check_ways(5'd3, 2'b00);
    check_ways(5'd7, 2'b00);
    refill(5'd9, 7'h44, 1'b0, 0, 0, 1'b0);
    check_ways(5'd9, 2'b01);

    // Miss and invalidate in the same IDLE cycle
    @(posedge clk); #1;
    lookup_valid_i = 1'b1; lookup_set_i = 5'd12; lookup_tag_i = 7'h12; invalidate_i = 1'b1;
    @(negedge clk);
    check_eq("inval_miss_stall", 32'(stall_o), 32'd1);
    @(posedge clk); #1;
    lookup_valid_i = 1'b0; invalidate_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("inval_miss_no_req", 32'(mem_req_valid_o), 32'd0);
    end
    check_ways(5'd9, 2'b00);

    // Reset during WAIT aborts the refill
    refill(5'd4, 7'h0A, 1'b0, 0, 0, 1'b0);
    check_ways(5'd4, 2'b01);
    @(posedge clk); #1;
    lookup_valid_i = 1'b1; lookup_set_i = 5'd2; lookup_tag_i = 7'h7F;
    exp_req.push_back({7'h7F, 5'd2});
    @(posedge clk); #1;
    lookup_valid_i = 1'b0; mem_req_ready_i = 1'b1;
    @(posedge clk); #1;
    mem_req_ready_i = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("abort_stall", 32'(stall_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    mem_rsp_valid_i = 1'b1;
    @(posedge clk); #1;
    mem_rsp_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("abort_no_wr", 32'(tag_wr_en_o), 32'd0);
      check_eq("abort_no_req", 32'(mem_req_valid_o), 32'd0);
    end
    for (int s = 0; s < 32; s++) check_ways(5'(s), 2'b00);

    check_eq("req_queue_drained", 32'(exp_req.size()), 32'd0);
    check_eq("wr_queue_drained", 32'(exp_wr.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
